disp_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Holds a double-buffered bank of eight hex digits plus decimal points.
- Cycles the digit index at a prescaled rate and drives the `sel`/`en` inputs of the downstream 8-way anode demultiplexer, plus the shared active-low cathode lines.
- Inserts a blanking window at each digit change to suppress ghosting; accepts new display content through a write-then-commit handshake applied only at frame boundaries.

---
 rtl/disp_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment display.
// Double-buffered digit bank (shadow written by the host, active scanned out), commit
// handshake that swaps banks only on frame wrap, per-slot blanking to suppress ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero suppression on the active bank).
module disp_scan_ctrl #(
  parameter int unsigned PRESCALE     = 12500,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [7:0] digit_mask,
  input  logic       commit,
  output logic       commit_busy,
  output logic       commit_ack,
  output logic [2:0] sel,
  output logic       en,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PcntMax  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BlankLen = PW'(BLANK_CYCLES);

  typedef enum logic {StIdle, StPending} commit_state_e;

  commit_state_e state_q, state_d;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;
  logic          ack_q, ack_d;

  logic [3:0] shd_val_q [8];
  logic [7:0] shd_dp_q;
  logic [3:0] act_val_q [8];
  logic [3:0] act_val_d [8];
  logic [7:0] act_dp_q, act_dp_d;

  logic       slot_tick;
  logic       frame_wrap;
  logic [7:0] lz_blank;

  // Active-low {g,f,e,d,c,b,a} hex font.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign slot_tick  = (pcnt_q == PcntMax);
  assign frame_wrap = slot_tick && (sel_q == 3'd7);

  // Prescaler and digit index advance.
  always_comb begin
    pcnt_d = slot_tick ? '0 : pcnt_q + PW'(1);
    sel_d  = slot_tick ? sel_q + 3'd1 : sel_q;
  end

  // Commit FSM: a pending request is serviced on the frame wrap edge; repeats are absorbed.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (commit) state_d = StPending;
      end
      StPending: begin
        if (frame_wrap) begin
          state_d = StIdle;
          ack_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Active bank takes the pre-write shadow contents on the copy edge.
  always_comb begin
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (ack_d) begin
      act_val_d = shd_val_q;
      act_dp_d  = shd_dp_q;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero run from digit 7 down; digit 0 always shown.
  always_comb begin
    logic run;
    lz_blank = '0;
    run      = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      run         = run && (act_val_d[i] == 4'h0) && !act_dp_d[i];
      lz_blank[i] = run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Output next-state: computed from next-cycle counters so registered outputs line up.
  always_comb begin
    en_d         = (pcnt_d < BlankLen) || !digit_mask[sel_d] || lz_blank[sel_d];
    seg_d        = hex_to_seg(act_val_d[sel_d]);
    dp_d         = !act_dp_d[sel_d];
    frame_tick_d = frame_wrap;
  end

  // Scan state, commit FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pcnt_q       <= '0;
      sel_q        <= '0;
      en_q         <= 1'b1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      ack_q        <= 1'b0;
      act_val_q    <= '{default: '0};
      act_dp_q     <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
      ack_q        <= ack_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
    end
  end

  // Shadow bank write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_val_q <= '{default: '0};
      shd_dp_q  <= '0;
    end else if (wr_en) begin
      shd_val_q[wr_addr] <= wr_data;
      shd_dp_q[wr_addr]  <= wr_dp;
    end
  end

  assign commit_busy = (state_q == StPending);
  assign commit_ack  = ack_q;
  assign sel         = sel_q;
  assign en          = en_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with PRESCALE=8, BLANK_CYCLES=2.
module tb_disp_scan_ctrl;

  localparam int P = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic [7:0] digit_mask = 8'hFF;
  logic       commit = 1'b0;
  logic       commit_busy, commit_ack, en, dp, frame_tick;
  logic [2:0] sel;
  logic [6:0] seg;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  disp_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .digit_mask(digit_mask), .commit(commit), .commit_busy(commit_busy),
    .commit_ack(commit_ack), .sel(sel), .en(en), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step(1);
    commit = 1'b0;
  endtask

  // Leaves the bench on the negedge of the frame_tick cycle (slot 0, pcnt 0).
  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (commit_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", sel); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL rst_en got %b want 1", en); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %b want 1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp got %b want 1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_ft got %b want 0", frame_tick); end
    checks++; if (commit_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", commit_ack); end
    checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", commit_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 72; k++) begin
      checks++;
      if (sel !== 3'((k / P) % 8)) begin
        errors++; $display("FAIL scan_sel k=%0d got %0d want %0d", k, sel, (k / P) % 8);
      end
      checks++;
      if (en !== 1'((k % P) < B)) begin
        errors++; $display("FAIL scan_en k=%0d got %b want %b", k, en, (k % P) < B);
      end
      checks++;
      if (frame_tick !== 1'(k == 64)) begin
        errors++; $display("FAIL scan_ft k=%0d got %b want %b", k, frame_tick, k == 64);
      end
      if (k % P == 4) begin
        checks++;
        if (seg !== 7'b1000000) begin
          errors++; $display("FAIL scan_seg0 k=%0d got %b want 1000000", k, seg);
        end
      end
      step(1);
    end
  endtask

  task automatic test_commit();
    bit ok;
    for (int i = 0; i < 8; i++) do_write(3'(i), 4'(i), 1'b0);
    pulse_commit();
    checks++;
    if (commit_busy !== 1'b1) begin errors++; $display("FAIL commit_busy got %b want 1", commit_busy); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (commit_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      checks++;
      if (commit_busy !== 1'b1) begin
        errors++; $display("FAIL pend_busy i=%0d got %b want 1", i, commit_busy);
      end
      if (en === 1'b0) begin
        checks++;
        if (seg !== 7'b1000000) begin
          errors++; $display("FAIL pre_ack_seg sel=%0d got %b want 1000000", sel, seg);
        end
      end
      step(1);
    end
    checks++; if (!ok) begin errors++; $display("FAIL commit_ack_timeout got none want pulse"); end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL ack_ft got %b want 1", frame_tick); end
    checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL ack_busy got %b want 0", commit_busy); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (seg !== seg_tab[k / P]) begin
        errors++; $display("FAIL digit_seg k=%0d got %b want %b", k, seg, seg_tab[k / P]);
      end
      checks++;
      if (commit_ack !== 1'(k == 0)) begin
        errors++; $display("FAIL ack_pulse k=%0d got %b want %b", k, commit_ack, k == 0);
      end
      checks++;
      if (dp !== 1'b1) begin errors++; $display("FAIL digit_dp k=%0d got %b want 1", k, dp); end
      step(1);
    end
  endtask

  task automatic test_mask();
    bit ok;
    digit_mask = 8'b1111_1110;
    sync_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_sync got none want frame_tick"); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (en !== 1'(((k % P) < B) || (k < P))) begin
        errors++; $display("FAIL mask_en k=%0d got %b want %b", k, en, ((k % P) < B) || (k < P));
      end
      step(1);
    end
    digit_mask = 8'hFF;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    int ack_k;
    sync_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_sync got none want frame_tick"); end
    step(5);
    pulse_commit();
    step(4);
    pulse_commit();
    checks++; if (commit_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", commit_busy); end
    n = 0;
    ack_k = -1;
    for (int k = 11; k < 140; k++) begin
      if (commit_ack === 1'b1) begin
        n++;
        ack_k = k;
      end
      step(1);
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL b2b_ack_count got %0d want 1", n); end
    checks++; if (ack_k !== 64) begin errors++; $display("FAIL b2b_ack_time got %0d want 64", ack_k); end
  endtask

  task automatic test_ack_write();
    bit ok;
    do_write(3'd2, 4'hA, 1'b1);
    pulse_commit();
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL aw_ack1 got none want pulse"); end
    do_write(3'd2, 4'hF, 1'b0);
    step(19);
    checks++; if (sel !== 3'd2) begin errors++; $display("FAIL aw_sel got %0d want 2", sel); end
    checks++; if (seg !== 7'b0001000) begin errors++; $display("FAIL aw_hidden_seg got %b want 0001000", seg); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL aw_hidden_dp got %b want 0", dp); end
    pulse_commit();
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL aw_ack2 got none want pulse"); end
    step(20);
    checks++; if (seg !== 7'b0001110) begin errors++; $display("FAIL aw_visible_seg got %b want 0001110", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL aw_visible_dp got %b want 1", dp); end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_lzb();
    bit ok;
    for (int i = 3; i < 8; i++) do_write(3'(i), 4'h0, 1'b0);
    do_write(3'd2, 4'h1, 1'b0);
    do_write(3'd1, 4'h2, 1'b0);
    do_write(3'd0, 4'h3, 1'b0);
    pulse_commit();
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lzb_ack got none want pulse"); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (en !== 1'(((k % P) < B) || (k / P >= 3))) begin
        errors++; $display("FAIL lzb_en k=%0d got %b want %b", k, en, ((k % P) < B) || (k / P >= 3));
      end
      step(1);
    end
    for (int i = 0; i < 8; i++) do_write(3'(i), 4'h0, 1'b0);
    pulse_commit();
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lzb0_ack got none want pulse"); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (en !== 1'(((k % P) < B) || (k / P != 0))) begin
        errors++; $display("FAIL lzb0_en k=%0d got %b want %b", k, en, ((k % P) < B) || (k / P != 0));
      end
      step(1);
    end
  endtask
`else
  task automatic test_zero_shown();
    bit ok;
    for (int i = 0; i < 8; i++) do_write(3'(i), 4'h0, 1'b0);
    pulse_commit();
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_ack got none want pulse"); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (en !== 1'((k % P) < B)) begin
        errors++; $display("FAIL zero_en k=%0d got %b want %b", k, en, (k % P) < B);
      end
      checks++;
      if (seg !== 7'b1000000) begin
        errors++; $display("FAIL zero_seg k=%0d got %b want 1000000", k, seg);
      end
      step(1);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    do_write(3'd4, 4'h9, 1'b1);
    sync_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_sync got none want frame_tick"); end
    step(20);
    pulse_commit();
    step(1);
    checks++; if (commit_busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre got %b want 1", commit_busy); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL rm_en_pre got %b want 0", en); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL rm_en got %b want 1", en); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rm_seg got %b want 1111111", seg); end
    checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", commit_busy); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rm_sel got %0d want 0", sel); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rm_dp got %b want 1", dp); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 72; k++) begin
      checks++;
      if (sel !== 3'((k / P) % 8)) begin
        errors++; $display("FAIL rm_scan_sel k=%0d got %0d want %0d", k, sel, (k / P) % 8);
      end
      checks++;
      if (en !== 1'((k % P) < B)) begin
        errors++; $display("FAIL rm_scan_en k=%0d got %b want %b", k, en, (k % P) < B);
      end
      checks++;
      if (commit_ack !== 1'b0) begin
        errors++; $display("FAIL rm_no_ack k=%0d got %b want 0", k, commit_ack);
      end
      if (k == 36) begin
        checks++;
        if (seg !== 7'b1000000) begin
          errors++; $display("FAIL rm_bank_cleared got %b want 1000000", seg);
        end
      end
      step(1);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_mask();
    test_back_to_back();
    test_ack_write();
`ifdef LEADING_ZERO_BLANK_EN
    test_lzb();
`else
    test_zero_shown();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
